exec_track: RTL
===============

# exec_track

Parametrised in-flight result tracker for the execute stage. It holds up to DEPTH issued instructions in age order and counts down each variable-latency result. It supplies youngest-first operand forwarding with a pending/stop indication, and retires results in order to the register-file write port. It generalises the fixed five-stage forwarding and wait-shift logic of the current execute stage. The new capabilities are configurable depth, latency, unit count and source-port count, plus event-completed (UART-style) entries.

## Interface
- DEPTH, 5: tracked slots (≥2); slot 0 youngest, slot DEPTH-1 retires
- NSRC, 2: forwarding lookup ports
- NUNIT, 8: result-producing units; UNIT_W = $clog2(NUNIT)
- LAT_W, 4: latency counter width
- XLEN, 32: data width
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- adv  in  1  shift all slots one place older this cycle (pipeline enable)
- adv_ok  out  1  high when slot DEPTH-1 is empty or ready; adv is ignored when low
- issue_valid  in  1  occupy slot 0 on adv; otherwise a bubble enters
- issue_we, issue_fp  in  1 each  writes a register / FP register file
- issue_rd  in  5  destination
- issue_lat  in  LAT_W  0 = data on issue_data now; L>0 = unit result valid L cycles later
- issue_unit  in  UNIT_W  unit that supplies the result
- issue_async  in  1  completion by ext_done rather than a counter
- issue_data  in  XLEN  immediate result (lat 0)
- unit_data  in  NUNIT*XLEN  unit outputs, unit u at [u*XLEN +: XLEN]
- ext_done, ext_data  in  1, XLEN  event completion for the oldest pending async entry
- src_fp  in  NSRC  source file select per port
- src_no  in  NSRC*5  source register per port
- fwd_hit  out  NSRC  a tracked entry matches
- fwd_data  out  NSRC*XLEN  forwarded value (source value when no hit)
- fwd_pending  out  NSRC  match is not ready; the issuer must not issue
- stop  out  1  OR of fwd_pending
- wb_valid, wb_fp, wb_rd, wb_data  out  1, 1, 5, XLEN  registered retire write

## Operation
- Slot fields: valid, we, fp, rd, unit, async, cnt[LAT_W-1:0], ready, data.
- Match rule: valid && we && fp==src_fp && rd==src_no && (fp || rd!=0). Integer r0 never matches.
- Forward priority: youngest matching slot wins.
  - ready → data
  - cnt==1 → unit_data[unit], not pending
  - otherwise pending
- Counter: cnt decrements every cycle, independent of adv. When cnt==1, data←unit_data[unit] and ready←1 at that edge. The capture applies to the slot's post-shift position when adv is high.
- lat 0 entries enter ready with issue_data.
- Async entries enter not ready. ext_done completes the oldest valid, not-ready async entry: data←ext_data, ready←1. ext_done with no such entry is ignored.
- An async entry issued in the same cycle as ext_done is not completed by that pulse.
- Retire: on adv && adv_ok, if slot DEPTH-1 is valid, registered outputs take wb_valid←we and wb_fp/wb_rd/wb_data. If that slot has cnt==1 in that cycle, wb_data is unit_data.
- Otherwise wb_valid←0.
- adv while adv_ok is low holds all slots. Counters still run and issue is dropped; the issuer must also hold.

## Timing
- Reset: all slots invalid, cnt 0, wb_valid 0, wb_fp 0, wb_rd 0, wb_data 0, adv_ok 1. fwd_* and stop are combinational and therefore 0 or pass-through.
- Reset mid-operation discards all in-flight entries immediately; no write is produced.
- Forward and stop are combinational from src_*, slot state and unit_data in the same cycle.
- Issue at edge t with lat L: ready from edge t+L, forwardable without stop during cycle t+L-1.
- Minimum retire latency: DEPTH adv cycles after issue. Write appears one cycle after the retiring adv edge.

## Configuration
- EXEC_TRACK_ASYNC_EN defined: async entries and ext_done/ext_data behave as above.
- Not defined: issue_async is treated as 0, ext_done/ext_data are ignored, and the async search logic is not built.

## Structure
- exec_track_pkg holds:
  - the slot struct typedef
  - the match function
  - the r0 constant
- exec_track_lookup is one sub-module, a single-port priority forward mux, instantiated NSRC times.

## Test plan
- Issue lat0 rd=3 data=0x11, then a reader src_no=3: fwd_hit=1, fwd_data=0x11, stop=0. After DEPTH adv cycles: wb_valid=1, wb_rd=3, wb_data=0x11.
- Issue lat4 unit 2 rd=5, with unit_data[2]=0xABCD at cycle t+3. Reader of r5: stop=1 for cycles t..t+2 and 0 at t+3 with fwd_data=0xABCD.
- Two writers to r7 (older 0x1, younger 0x2): forward returns 0x2. A writer to r0 never hits.
- fp rd=4 in flight with an int reader of r4: fwd_hit=0, fwd_data equals the source value.
- Async rd=9 reaching slot DEPTH-1 not ready: adv_ok=0 and slots hold. ext_done with ext_data=0x55 → adv_ok=1, and the next adv retires wb_data=0x55. Without EXEC_TRACK_ASYNC_EN the same entry retires immediately with issue_data.
- rstn low mid-flight with 3 pending entries: wb_valid=0, no hits, adv_ok=1.

Source files
------------

// File: rtl/exec_track_pkg.sv
// Shared types and helpers for the execute-stage in-flight result tracker.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package exec_track_pkg;

    localparam logic [4:0] R0 = 5'd0;

    // Fixed-width control fields of one tracked slot. The parameter-dependent
    // fields (cnt, unit, data) are held in parallel arrays in the user modules.
    typedef struct packed {
        logic       valid;
        logic       we;
        logic       fp;
        logic [4:0] rd;
        logic       async;
        logic       ready;
    } slot_t;

    // A source matches a slot writing the same register file and register;
    // integer r0 is hard-wired and never forwarded.
    function automatic logic slot_match(input slot_t s, input logic src_fp, input logic [4:0] src_no);
        return s.valid && s.we && (s.fp == src_fp) && (s.rd == src_no) && (src_fp || (src_no != R0));
    endfunction

endpackage

// File: rtl/exec_track_lookup.sv
// Single-port youngest-first operand forward mux over all tracked slots.
// Latency: combinational.
// Backpressure: none; pending tells the issuer to stall.
module exec_track_lookup
    import exec_track_pkg::*;
#(
    parameter int DEPTH  = 5,
    parameter int NUNIT  = 8,
    parameter int LAT_W  = 4,
    parameter int XLEN   = 32,
    parameter int UNIT_W = 3
) (
    input  slot_t                  slot      [DEPTH],
    input  logic [LAT_W-1:0]       cnt       [DEPTH],
    input  logic [UNIT_W-1:0]      unit_sel  [DEPTH],
    input  logic [XLEN-1:0]        data      [DEPTH],
    input  logic [NUNIT*XLEN-1:0]  unit_data,
    input  logic                   src_fp,
    input  logic [4:0]             src_no,
    input  logic [XLEN-1:0]        src_val,
    output logic                   hit,
    output logic [XLEN-1:0]        fwd,
    output logic                   pending
);

    logic [DEPTH-1:0] unused_async;

    for (genvar i = 0; i < DEPTH; i++) begin : g_unused
        assign unused_async[i] = slot[i].async;
    end

    // Scan oldest to youngest so the youngest matching slot has the final say.
    always_comb begin
        hit     = 1'b0;
        pending = 1'b0;
        fwd     = src_val;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (slot_match(slot[i], src_fp, src_no)) begin
                hit = 1'b1;
                if (slot[i].ready) begin
                    fwd     = data[i];
                    pending = 1'b0;
                end else if (cnt[i] == LAT_W'(1)) begin
                    fwd     = unit_data[int'(unit_sel[i])*XLEN +: XLEN];
                    pending = 1'b0;
                end else begin
                    fwd     = src_val;
                    pending = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/exec_track.sv
// In-flight result tracker: age-ordered slots, latency countdown, forwarding, in-order retire.
// Latency: forward combinational; write-back registered one cycle after the retiring adv edge.
// Backpressure: adv_ok low while the oldest slot is unresolved; adv and issue are then ignored.
// Optional: EXEC_TRACK_ASYNC_EN enables event-completed (ext_done) entries.
module exec_track
    import exec_track_pkg::*;
#(
    parameter  int DEPTH  = 5,
    parameter  int NSRC   = 2,
    parameter  int NUNIT  = 8,
    parameter  int LAT_W  = 4,
    parameter  int XLEN   = 32,
    localparam int UNIT_W = (NUNIT > 1) ? $clog2(NUNIT) : 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   adv,
    output logic                   adv_ok,
    input  logic                   issue_valid,
    input  logic                   issue_we,
    input  logic                   issue_fp,
    input  logic [4:0]             issue_rd,
    input  logic [LAT_W-1:0]       issue_lat,
    input  logic [UNIT_W-1:0]      issue_unit,
    input  logic                   issue_async,
    input  logic [XLEN-1:0]        issue_data,
    input  logic [NUNIT*XLEN-1:0]  unit_data,
    input  logic                   ext_done,
    input  logic [XLEN-1:0]        ext_data,
    input  logic [NSRC-1:0]        src_fp,
    input  logic [NSRC*5-1:0]      src_no,
    // register-file read values, passed through when no slot matches
    input  logic [NSRC*XLEN-1:0]   src_data,
    output logic [NSRC-1:0]        fwd_hit,
    output logic [NSRC*XLEN-1:0]   fwd_data,
    output logic [NSRC-1:0]        fwd_pending,
    output logic                   stop,
    output logic                   wb_valid,
    output logic                   wb_fp,
    output logic [4:0]             wb_rd,
    output logic [XLEN-1:0]        wb_data
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAIL  = DEPTH - 1;

    slot_t             slot_q [DEPTH], slot_u [DEPTH], slot_d [DEPTH];
    logic [LAT_W-1:0]  cnt_q  [DEPTH], cnt_u  [DEPTH], cnt_d  [DEPTH];
    logic [UNIT_W-1:0] unit_q [DEPTH], unit_d [DEPTH];
    logic [XLEN-1:0]   data_q [DEPTH], data_u [DEPTH], data_d [DEPTH];

    logic              do_adv;
    logic              new_async;
    logic              ext_fire;
    logic [IDX_W-1:0]  ext_idx;

    // A slot whose counter reads 1 resolves at this edge, so it may retire now.
    assign adv_ok = !slot_q[TAIL].valid || slot_q[TAIL].ready || (cnt_q[TAIL] == LAT_W'(1));
    assign do_adv = adv && adv_ok;

`ifdef EXEC_TRACK_ASYNC_EN
    logic ext_hit;

    // Find the oldest valid, unresolved async slot; ext_done completes only that one.
    always_comb begin
        ext_hit = 1'b0;
        ext_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_q[i].valid && slot_q[i].async && !slot_q[i].ready) begin
                ext_hit = 1'b1;
                ext_idx = IDX_W'(i);
            end
        end
    end

    assign ext_fire  = ext_done && ext_hit;
    assign new_async = issue_async;
`else
    logic unused_ext;

    assign unused_ext = ^{ext_done, ext_data, issue_async};
    assign ext_fire   = 1'b0;
    assign ext_idx    = '0;
    assign new_async  = 1'b0;
`endif

    // Per-slot update in place: countdown, unit capture at cnt==1, event completion.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_u[i] = slot_q[i];
            data_u[i] = data_q[i];
            cnt_u[i]  = (cnt_q[i] != '0) ? cnt_q[i] - LAT_W'(1) : cnt_q[i];
            if (cnt_q[i] == LAT_W'(1)) begin
                slot_u[i].ready = 1'b1;
                data_u[i]       = unit_data[int'(unit_q[i])*XLEN +: XLEN];
            end
            if (ext_fire && (ext_idx == IDX_W'(i))) begin
                slot_u[i].ready = 1'b1;
                data_u[i]       = ext_data;
            end
        end
    end

    // Shift the updated slots one place older on adv, inserting the issue (or a bubble) at slot 0.
    always_comb begin
        if (do_adv) begin
            slot_d[0].valid = issue_valid;
            slot_d[0].we    = issue_we;
            slot_d[0].fp    = issue_fp;
            slot_d[0].rd    = issue_rd;
            slot_d[0].async = new_async;
            slot_d[0].ready = issue_valid && !new_async && (issue_lat == '0);
            cnt_d[0]        = (issue_valid && !new_async) ? issue_lat : '0;
            unit_d[0]       = issue_unit;
            data_d[0]       = issue_data;
        end else begin
            slot_d[0] = slot_u[0];
            cnt_d[0]  = cnt_u[0];
            unit_d[0] = unit_q[0];
            data_d[0] = data_u[0];
        end
        for (int i = 1; i < DEPTH; i++) begin
            slot_d[i] = do_adv ? slot_u[i-1] : slot_u[i];
            cnt_d[i]  = do_adv ? cnt_u[i-1]  : cnt_u[i];
            unit_d[i] = do_adv ? unit_q[i-1] : unit_q[i];
            data_d[i] = do_adv ? data_u[i-1] : data_u[i];
        end
    end

    // Slot storage; reset discards everything in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
                cnt_q[i]  <= '0;
                unit_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            slot_q <= slot_d;
            cnt_q  <= cnt_d;
            unit_q <= unit_d;
            data_q <= data_d;
        end
    end

    // Registered retire port; data_u already carries a same-cycle unit capture.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wb_valid <= 1'b0;
            wb_fp    <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
        end else if (do_adv && slot_q[TAIL].valid) begin
            wb_valid <= slot_q[TAIL].we;
            wb_fp    <= slot_q[TAIL].fp;
            wb_rd    <= slot_q[TAIL].rd;
            wb_data  <= data_u[TAIL];
        end else begin
            wb_valid <= 1'b0;
        end
    end

    for (genvar p = 0; p < NSRC; p++) begin : g_lookup
        exec_track_lookup #(
            .DEPTH (DEPTH),
            .NUNIT (NUNIT),
            .LAT_W (LAT_W),
            .XLEN  (XLEN),
            .UNIT_W(UNIT_W)
        ) u_lookup (
            .slot     (slot_q),
            .cnt      (cnt_q),
            .unit_sel (unit_q),
            .data     (data_q),
            .unit_data(unit_data),
            .src_fp   (src_fp[p]),
            .src_no   (src_no[p*5 +: 5]),
            .src_val  (src_data[p*XLEN +: XLEN]),
            .hit      (fwd_hit[p]),
            .fwd      (fwd_data[p*XLEN +: XLEN]),
            .pending  (fwd_pending[p])
        );
    end

    assign stop = |fwd_pending;

endmodule
